// File: rtl/cpu_step_clock_ctrl.sv
// Step-clock controller: turns the divided slow clocks and board buttons into single-cycle
// cpu_enable pulses with run/halt/single-step control. Optional pulse counter: STEP_COUNT_EN.
module cpu_step_clock_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned COUNT_W         = 16
) (
   input  logic               clock_in_50M,
   input  logic               reset,
   input  logic               clock_1H,
   input  logic               clock_10H,
   input  logic               clock_100H,
   input  logic [1:0]         speed_sel,
   input  logic               run_btn,
   input  logic               step_btn,
   input  logic               halt_req,
   output logic               cpu_enable,
   output logic               running,
   output logic [COUNT_W-1:0] step_count
);
   localparam int unsigned DB_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int unsigned N_SLOW   = 3;
   localparam int unsigned N_BTN    = 2;
   localparam int unsigned BTN_RUN  = 0;
   localparam int unsigned BTN_STEP = 1;

   typedef enum logic [1:0] {
      S_HALT = 2'd0,
      S_RUN  = 2'd1,
      S_STEP = 2'd2
   } state_e;

   logic [N_SLOW-1:0] slow_raw;
   logic [N_SLOW-1:0] slow_s1_q, slow_s1_d, slow_s2_q, slow_s2_d, slow_s3_q, slow_s3_d;
   logic [N_SLOW-1:0] tick_q, tick_d;
   logic [N_BTN-1:0]  btn_raw, press;
   logic              sel_tick;
   state_e            state_q, state_d;
   logic              cpu_enable_q, cpu_enable_d;
   logic              running_q, running_d;

   assign slow_raw = {clock_100H, clock_10H, clock_1H};
   assign btn_raw  = {step_btn, run_btn};

   // Slow-clock synchronisers and rising-edge ticks, always active
   always_comb begin
      slow_s1_d = slow_raw;
      slow_s2_d = slow_s1_q;
      slow_s3_d = slow_s2_q;
      tick_d    = slow_s2_q & ~slow_s3_q;
   end

   // Per-button synchroniser, debouncer and press detector
   for (genvar g = 0; g < N_BTN; g++) begin : g_btn
      logic            s1_q, s1_d, s2_q, s2_d;
      logic            lvl_q, lvl_d, prev_q, prev_d;
      logic [DB_W-1:0] cnt_q, cnt_d;

      always_comb begin
         s1_d   = btn_raw[g];
         s2_d   = s1_q;
         prev_d = lvl_q;
         lvl_d  = lvl_q;
         cnt_d  = '0;
         if (s2_q != lvl_q) begin
            if (32'(cnt_q) + 32'd1 >= DEBOUNCE_CYCLES - 32'd1) begin
               lvl_d = s2_q;
            end else begin
               cnt_d = cnt_q + DB_W'(1);
            end
         end
      end

      always_ff @(posedge clock_in_50M or posedge reset) begin
         if (reset) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            lvl_q  <= 1'b0;
            prev_q <= 1'b0;
            cnt_q  <= '0;
         end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            lvl_q  <= lvl_d;
            prev_q <= prev_d;
            cnt_q  <= cnt_d;
         end
      end

      assign press[g] = lvl_q & ~prev_q;
   end

   always_comb begin
      sel_tick = 1'b0;
      case (speed_sel)
         2'b00:   sel_tick = tick_q[0];
         2'b01:   sel_tick = tick_q[1];
         2'b10:   sel_tick = tick_q[2];
         default: sel_tick = 1'b0;
      endcase
   end

   // Run/halt/step FSM; a pulse right after a pulse is suppressed so RUN never doubles up
   always_comb begin
      state_d      = state_q;
      cpu_enable_d = 1'b0;
      case (state_q)
         S_HALT: begin
            if (press[BTN_RUN]) begin
               state_d = S_RUN;
            end else if (press[BTN_STEP]) begin
               state_d = S_STEP;
            end
         end
         S_RUN: begin
            if (halt_req || press[BTN_RUN]) begin
               state_d = S_HALT;
            end else if ((sel_tick || (speed_sel == 2'b11 && press[BTN_STEP])) && !cpu_enable_q) begin
               cpu_enable_d = 1'b1;
            end
         end
         S_STEP: begin
            cpu_enable_d = 1'b1;
            state_d      = S_HALT;
         end
         default: state_d = S_HALT;
      endcase
      running_d = (state_d == S_RUN);
   end

   always_ff @(posedge clock_in_50M or posedge reset) begin
      if (reset) begin
         slow_s1_q    <= '0;
         slow_s2_q    <= '0;
         slow_s3_q    <= '0;
         tick_q       <= '0;
         state_q      <= S_HALT;
         cpu_enable_q <= 1'b0;
         running_q    <= 1'b0;
      end else begin
         slow_s1_q    <= slow_s1_d;
         slow_s2_q    <= slow_s2_d;
         slow_s3_q    <= slow_s3_d;
         tick_q       <= tick_d;
         state_q      <= state_d;
         cpu_enable_q <= cpu_enable_d;
         running_q    <= running_d;
      end
   end

   assign cpu_enable = cpu_enable_q;
   assign running    = running_q;

`ifdef STEP_COUNT_EN
   logic [COUNT_W-1:0] step_count_q, step_count_d;

   // Counts in step with the enable register so both change on the same edge
   always_comb begin
      step_count_d = step_count_q + COUNT_W'(cpu_enable_d);
   end

   always_ff @(posedge clock_in_50M or posedge reset) begin
      if (reset) begin
         step_count_q <= '0;
      end else begin
         step_count_q <= step_count_d;
      end
   end

   assign step_count = step_count_q;
`else
   assign step_count = '0;
`endif

endmodule

// File: tb/tb_cpu_step_clock_ctrl.sv
// Bench for cpu_step_clock_ctrl: directed latency sequences, a vector table and random
// stimulus, all checked against a sample-history reference model.
module tb_cpu_step_clock_ctrl;
   localparam int unsigned DEB = 4;
   localparam int unsigned CW  = 4;

   logic          clk;
   logic          rst;
   logic [2:0]    slow;
   logic [1:0]    speed_sel;
   logic          run_btn, step_btn, halt_req;
   logic          cpu_enable, running;
   logic [CW-1:0] step_count;

   cpu_step_clock_ctrl #(.DEBOUNCE_CYCLES(DEB), .COUNT_W(CW)) dut (
      .clock_in_50M (clk),
      .reset        (rst),
      .clock_1H     (slow[0]),
      .clock_10H    (slow[1]),
      .clock_100H   (slow[2]),
      .speed_sel    (speed_sel),
      .run_btn      (run_btn),
      .step_btn     (step_btn),
      .halt_req     (halt_req),
      .cpu_enable   (cpu_enable),
      .running      (running),
      .step_count   (step_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk, n_pass, pulses;

   // Reference model: raw input samples per edge, debounced levels, run/step mode
   logic [2:0] m_ch [3];
   logic [1:0] m_bh [2];
   logic [2:0] m_tick;
   logic [1:0] m_deb, m_debp;
   int         m_run_len [2];
   bit         m_run, m_pend, m_en;
   int         m_cnt;

   typedef struct {
      logic [1:0] sel;
      logic [2:0] mask;
      int         rises;
      bit         halt;
      int         exp_pulses;
      bit         exp_run;
   } vec_t;
   vec_t vecs [6];

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
   endtask

   function automatic int exp_cnt(input int c);
`ifdef STEP_COUNT_EN
      return c;
`else
      return 0;
`endif
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 3; i++) m_ch[i] = '0;
      for (int i = 0; i < 2; i++) begin
         m_bh[i] = '0;
         m_run_len[i] = 0;
      end
      m_tick = '0; m_deb = '0; m_debp = '0;
      m_run = 0; m_pend = 0; m_en = 0; m_cnt = 0;
   endtask

   // One clock edge of the model, using the inputs as sampled at that edge
   task automatic model_step();
      bit sel, rp, sp, en_n, syn;
      sel  = (speed_sel == 2'd3) ? 1'b0 : m_tick[speed_sel];
      rp   = m_deb[0] & ~m_debp[0];
      sp   = m_deb[1] & ~m_debp[1];
      en_n = 0;
      if (m_pend) begin
         en_n = 1; m_pend = 0;
      end else if (m_run) begin
         if (halt_req || rp) m_run = 0;
         else if ((sel || (speed_sel == 2'd3 && sp)) && !m_en) en_n = 1;
      end else begin
         if (rp) m_run = 1;
         else if (sp) m_pend = 1;
      end
      m_en  = en_n;
      m_cnt = (m_cnt + int'(en_n)) % (1 << CW);
      // tick register holds "sample two edges ago high, three edges ago low"
      m_tick  = m_ch[1] & ~m_ch[2];
      m_ch[2] = m_ch[1]; m_ch[1] = m_ch[0]; m_ch[0] = slow;
      m_debp = m_deb;
      for (int i = 0; i < 2; i++) begin
         syn = m_bh[1][i];
         if (syn != m_deb[i]) begin
            m_run_len[i]++;
            if (m_run_len[i] == int'(DEB) - 1) begin
               m_deb[i] = syn;
               m_run_len[i] = 0;
            end
         end else begin
            m_run_len[i] = 0;
         end
      end
      m_bh[1] = m_bh[0]; m_bh[0] = {step_btn, run_btn};
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
      if (cpu_enable) pulses++;
      chk("cpu_enable", int'(cpu_enable), int'(m_en));
      chk("running", int'(running), int'(m_run));
      chk("step_count", int'(step_count), exp_cnt(m_cnt));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      model_clear();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic press(input int b);
      if (b == 0) run_btn = 1'b1; else step_btn = 1'b1;
      repeat (DEB + 4) cyc();
      if (b == 0) run_btn = 1'b0; else step_btn = 1'b0;
      repeat (DEB + 4) cyc();
   endtask

   task automatic toggle_clk(input logic [2:0] mask, input int n);
      repeat (n) begin
         slow = slow | mask;
         repeat (3) cyc();
         slow = slow & ~mask;
         repeat (3) cyc();
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;
      n_chk = 0; n_pass = 0; pulses = 0;
      rst = 1'b1; slow = '0; speed_sel = 2'd0;
      run_btn = 1'b0; step_btn = 1'b0; halt_req = 1'b0;
      vecs[0] = '{2'd0, 3'b111, 2, 1'b0, 2, 1'b1};
      vecs[1] = '{2'd1, 3'b001, 3, 1'b0, 0, 1'b1};
      vecs[2] = '{2'd2, 3'b100, 4, 1'b0, 4, 1'b1};
      vecs[3] = '{2'd1, 3'b110, 2, 1'b0, 2, 1'b1};
      vecs[4] = '{2'd3, 3'b111, 3, 1'b0, 0, 1'b1};
      vecs[5] = '{2'd0, 3'b001, 2, 1'b1, 0, 1'b0};

      do_reset();
      chk("rst_enable", int'(cpu_enable), 0);
      chk("rst_running", int'(running), 0);
      chk("rst_count", int'(step_count), 0);

      // 1: run at 10 Hz, three rises, pulse on the 4th edge after each rise
      speed_sel = 2'd1;
      press(0);
      chk("t1_running", int'(running), 1);
      pulses = 0;
      for (int r = 0; r < 3; r++) begin
         slow[1] = 1'b1;
         for (int j = 1; j <= 6; j++) begin
            cyc();
            chk("t1_latency", int'(cpu_enable), (j == 4) ? 1 : 0);
            if (j == 3) slow[1] = 1'b0;
         end
      end
      chk("t1_pulses", pulses, 3);
      chk("t1_count", int'(step_count), exp_cnt(3));

      // 2: halt, hold step for 10 cycles -> single pulse on the 7th edge
      press(0);
      chk("t2_halted", int'(running), 0);
      pulses = 0;
      step_btn = 1'b1;
      for (int j = 1; j <= 10; j++) begin
         cyc();
         chk("t2_latency", int'(cpu_enable), (j == 7) ? 1 : 0);
      end
      step_btn = 1'b0;
      repeat (10) cyc();
      chk("t2_pulses", pulses, 1);
      chk("t2_halted_after", int'(running), 0);

      // 3: bouncing step button never gets accepted
      pulses = 0;
      for (int k = 0; k < 6; k++) begin
         step_btn = (k % 2 == 0);
         cyc();
      end
      step_btn = 1'b0;
      repeat (10) cyc();
      chk("t3_pulses", pulses, 0);
      chk("t3_count", int'(step_count), exp_cnt(4));

      // 4: halt_req coincident with a 1 Hz tick wins
      speed_sel = 2'd0;
      press(0);
      slow[0] = 1'b1;
      repeat (3) cyc();
      halt_req = 1'b1;
      cyc();
      chk("t4_enable", int'(cpu_enable), 0);
      chk("t4_running", int'(running), 0);
      halt_req = 1'b0;
      slow[0] = 1'b0;
      repeat (4) cyc();

      // 5: manual mode ignores slow clocks; a step press gives one pulse while running
      press(0);
      speed_sel = 2'd3;
      pulses = 0;
      toggle_clk(3'b111, 4);
      chk("t5_no_pulses", pulses, 0);
      press(1);
      chk("t5_step_pulse", pulses, 1);
      chk("t5_running", int'(running), 1);

      // Vector table: speed selection against which clocks toggle
      for (int v = 0; v < 6; v++) begin
         halt_req = 1'b0;
         if (!m_run) press(0);
         speed_sel = vecs[v].sel;
         pulses = 0;
         halt_req = vecs[v].halt;
         toggle_clk(vecs[v].mask, vecs[v].rises);
         halt_req = 1'b0;
         chk($sformatf("vec%0d_pulses", v), pulses, vecs[v].exp_pulses);
         chk($sformatf("vec%0d_running", v), int'(running), int'(vecs[v].exp_run));
      end

      // Random stimulus against the model
      for (int c = 0; c < 600; c++) begin
         for (int b = 0; b < 3; b++)
            if ($urandom_range(0, 7) == 0) slow[b] = ~slow[b];
         if ($urandom_range(0, 49) == 0) speed_sel = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 39) == 0) run_btn = ~run_btn;
         if ($urandom_range(0, 24) == 0) step_btn = ~step_btn;
         halt_req = ($urandom_range(0, 30) == 0);
         cyc();
      end
      slow = '0; run_btn = 1'b0; step_btn = 1'b0; halt_req = 1'b0;

      // 6: 17 pulses wrap the 4-bit counter to 1, then reset lands mid-pulse
      do_reset();
      speed_sel = 2'd2;
      press(0);
      pulses = 0;
      toggle_clk(3'b100, 17);
      chk("t6_pulses", pulses, 17);
      chk("t6_wrap", int'(step_count), exp_cnt(1));
      slow[2] = 1'b1;
      found = 0;
      for (int j = 0; j < 8 && !found; j++) begin
         cyc();
         if (cpu_enable) found = 1;
      end
      chk("t6_pulse_seen", int'(found), 1);
      #2 rst = 1'b1;
      #1;
      chk("t6_rst_enable", int'(cpu_enable), 0);
      chk("t6_rst_count", int'(step_count), 0);
      chk("t6_rst_running", int'(running), 0);
      model_clear();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      pulses = 0;
      repeat (12) cyc();
      slow = '0;
      repeat (4) cyc();
      chk("t6_no_pulse_after_reset", pulses, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
